// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for sync_fifo
// Purpose: default geometry, read-mode constants and the per-edge
//          operation classification used by the FIFO top.
// Ports:   none (package).
package fifo_pkg;

   localparam int DSIZE_DEF = 8;
   localparam int ASIZE_DEF = 4;

   // Read modes
   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // Encoding is {write accepted, read accepted}
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_WRRD = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/sfifo_mem.sv
// rtl/sfifo_mem.sv - FIFO storage array
// Purpose: DEPTH x DSIZE register array, synchronous write,
//          combinational read by address. Not reset.
// Ports:   clk   - clock
//          we    - write enable
//          waddr - write address
//          wdata - write data
//          raddr - read address
//          rdata - read data (combinational)
module sfifo_mem
   import fifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int ASIZE = ASIZE_DEF
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ASIZE-1:0] waddr,
   input  logic [DSIZE-1:0] wdata,
   input  logic [ASIZE-1:0] raddr,
   output logic [DSIZE-1:0] rdata
);

   logic [DSIZE-1:0] mem_q [0:(1<<ASIZE)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level flags and error pulses
// Purpose: pointer, count, flag and pulse logic around sfifo_mem,
//          with standard registered read or first-word-fall-through.
// Ports:   clk          - clock
//          rst          - synchronous reset, active high
//          winc / wdata - write request and data
//          rinc         - read request (pop)
//          rdata        - read data
//          rvalid       - rdata qualifier
//          wfull/rempty - full / empty flags
//          almost_full  - count >= AFULL_TH
//          almost_empty - count <= AEMPTY_TH
//          count        - words held, 0..DEPTH
//          wovf / rudf  - one-cycle pulses for rejected write / read
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DSIZE     = DSIZE_DEF,
   parameter int ASIZE     = ASIZE_DEF,
   parameter int AFULL_TH  = (1 << ASIZE) - 2,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = FIFO_STD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rvalid,
   output logic             wfull,
   output logic             rempty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [ASIZE:0]   count,
   output logic             wovf,
   output logic             rudf
);

   localparam logic [ASIZE:0] DEPTH_C  = {1'b1, {ASIZE{1'b0}}};
   localparam logic [ASIZE:0] ONE_C    = {{ASIZE{1'b0}}, 1'b1};
   localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
   localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);

   logic [ASIZE:0]   wptr_q, wptr_d;
   logic [ASIZE:0]   rptr_q, rptr_d;
   logic [ASIZE:0]   count_q, count_d;
   logic             wfull_q, wfull_d;
   logic             rempty_q, rempty_d;
   logic             afull_q, afull_d;
   logic             aempty_q, aempty_d;
   logic             wovf_q, wovf_d;
   logic             rudf_q, rudf_d;
   logic             wr_acc, rd_acc;
   fifo_op_e         op;
   logic [DSIZE-1:0] mem_rdata;

   sfifo_mem #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wptr_q[ASIZE-1:0]),
      .wdata (wdata),
      .raddr (rptr_q[ASIZE-1:0]),
      .rdata (mem_rdata)
   );

   always_comb begin
      // Acceptance uses the registered flags from before the edge, so a
      // full FIFO still takes a read (and rejects the write) and an empty
      // FIFO still takes a write (and rejects the read).
      wr_acc  = winc & ~wfull_q;
      rd_acc  = rinc & ~rempty_q;
      op      = fifo_op_e'({wr_acc, rd_acc});
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      case (op)
         OP_WR: begin
            wptr_d  = wptr_q + ONE_C;
            count_d = count_q + ONE_C;
         end
         OP_RD: begin
            rptr_d  = rptr_q + ONE_C;
            count_d = count_q - ONE_C;
         end
         OP_WRRD: begin
            wptr_d  = wptr_q + ONE_C;
            rptr_d  = rptr_q + ONE_C;
         end
         default: ;
      endcase
      wfull_d  = (count_d == DEPTH_C);
      rempty_d = (count_d == '0);
      afull_d  = (count_d >= AFULL_C);
      aempty_d = (count_d <= AEMPTY_C);
      wovf_d   = winc & wfull_q;
      rudf_d   = rinc & rempty_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         wfull_q  <= 1'b0;
         rempty_q <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         wovf_q   <= 1'b0;
         rudf_q   <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         wfull_q  <= wfull_d;
         rempty_q <= rempty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         wovf_q   <= wovf_d;
         rudf_q   <= rudf_d;
      end
   end

   generate
      if (FWFT == FIFO_FWFT) begin : g_fwft
         // Head word is visible straight from the array whenever non-empty.
         assign rdata  = mem_rdata;
         assign rvalid = ~rempty_q;
      end else begin : g_std
         logic [DSIZE-1:0] rdata_q;
         logic             rvalid_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rvalid_q <= rd_acc;
               if (rd_acc) begin
                  rdata_q <= mem_rdata;
               end
            end
         end
         assign rdata  = rdata_q;
         assign rvalid = rvalid_q;
      end
   endgenerate

   assign wfull        = wfull_q;
   assign rempty       = rempty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign wovf         = wovf_q;
   assign rudf         = rudf_q;

endmodule
